reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement buffer downstream of the ALU reservation station. It records each issued instruction in program order and accepts the station's computed result (tag, value). It broadcasts that result on the common data bus to the stations, then retires entries in order to the register file. On a mispredicted branch it redirects fetch and flushes.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, 2..16
- PTR_W, 3, log2(DEPTH)

Ports:
- clk_in  in  1  clock; all state updates on rising edge
- rst_in  in  1  synchronous, active-low reset
- rdy_in  in  1  0 = pause: state held; pulse outputs forced 0
- issue_valid  in  1  allocate one entry this cycle
- issue_tag  in  4  station tag that will produce the result; 4'b0000 = None
- issue_rd  in  5  destination register; 0 = no write
- issue_addr  in  32  instruction PC
- issue_branch  in  1  entry is a branch/jump
- issue_pred_next  in  32  predicted next PC (branches only)
- issue_full  out  1  count == DEPTH, combinational
- wb_valid  in  1  result available (station submit_valid)
- wb_tag  in  4  station submit_tag
- wb_val  in  32  station submit_val; for branches, the resolved next PC
- cdb_active  out  1  registered broadcast strobe
- cdb_tag  out  4  broadcast tag
- cdb_val  out  32  broadcast value
- cdb_addr  out  32  PC of the matched entry; 0 if no match
- commit_valid  out  1  registered retire strobe
- commit_rd  out  5  register to write
- commit_val  out  32  value to write
- commit_tag  out  4  tag of the retired entry (regfile clears its qj/qk if equal)
- flush  out  1  one-cycle mispredict pulse
- redirect_addr  out  32  correct next PC, valid with flush

## Operation
- Entry fields: busy, ready, tag, rd, addr, branch, pred_next, val. head/tail are PTR_W bits and wrap modulo DEPTH; count is PTR_W+1 bits.
- Issue: when issue_valid && !issue_full && !flush_pending:
  - entry[tail] <= {busy=1, ready=0, ...}
  - tail++
  - issue_valid while full is ignored (issuer must stall on issue_full).
- Writeback when wb_valid:
  - Match the oldest busy && !ready entry with tag == wb_tag, searching from head. Tags recycle, so only the oldest unready holder matches.
  - On match: val <= wb_val, ready <= 1.
  - The CDB registers are loaded regardless of match: cdb_active=1, cdb_tag, cdb_val=wb_val, cdb_addr=entry addr (or 0).
  - wb_tag == None is ignored entirely.
- Commit: when entry[head] is busy && ready at the clock edge:
  - commit_valid=1, commit_rd, commit_val, commit_tag loaded
  - busy cleared, head++
  - At most one commit per cycle.
- Mispredict: the committing entry has branch && val != pred_next.
  - Additionally pulse flush=1 and set redirect_addr=val.
  - In the same edge, clear all busy bits and set head=tail=count=0.
  - commit_rd is forced to 0 unless the branch has a link rd, which is still written.
- Simultaneous issue + commit: count unchanged; full status is taken from count before the edge.
- Simultaneous writeback and flush: the entry update is discarded; the CDB still broadcasts that cycle.

## Timing
- Reset (rst_in==0 at edge):
  - all entries cleared, head=tail=count=0
  - cdb_active=commit_valid=flush=0
  - cdb_tag=commit_tag=0, cdb_val=cdb_addr=commit_val=redirect_addr=0, commit_rd=0
  - issue_full=0
- Reset mid-operation drops all in-flight entries with no commit.
- Issue at edge N: the entry is visible after N and is commit-eligible once ready.
- wb at edge N: cdb_* are valid in cycle N+1 for exactly one cycle. The earliest commit of that entry is edge N+1, giving commit_valid in cycle N+2.
- All pulse outputs are high for one cycle only.
- With rdy_in=0 the pulse outputs are 0 and the payload outputs hold.

## Configuration
- REORDER_BUFFER_BYPASS_EN defined: if wb matches the head entry at edge N, that entry commits at the same edge N. commit_valid and cdb_active then appear together in cycle N+1, and the head entry skips the ready state.
- Not defined: the path is always wb -> ready -> commit, adding one cycle of retire latency.

## Test plan
- Reset: hold rst_in=0 for 2 cycles -> all outputs 0 and issue_full=0. Issue 8 entries -> issue_full=1; a 9th issue is ignored and tail does not move.
- In-order retire: issue tags 1, 2, 3 (rd 5, 6, 7); wb tag3=30, then tag1=10, then tag2=20.
  - cdb order is 3, 1, 2.
  - Commits are rd5=10, rd6=20, rd7=30, in that order.
- Tag reuse: issue tag1 twice; wb tag1=0xA, then tag1=0xB -> the older entry commits 0xA and the younger commits 0xB.
- Mispredict: issue a branch (pred_next=0x104) followed by 3 more entries; wb branch val=0x200 -> commit plus flush=1 with redirect_addr=0x200; count=0 and the later wbs cause no commits.
- Wrap: issue and commit 20 instructions through DEPTH=8 -> commit_val sequence is correct and head/tail wrap cleanly.
- Bypass on/off: issue tag1 and wb at edge N -> commit_valid in cycle N+1 with REORDER_BUFFER_BYPASS_EN defined, N+2 without; rdy_in=0 for 3 cycles mid-stream delays by exactly 3.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, broadcast, retire and redirect signals of the reorder buffer.
// The master side (issue stage / stations) drives issue_* and wb_*; the buffer is the slave.
interface reorder_buffer_if;
    logic        issue_valid;
    logic [3:0]  issue_tag;
    logic [4:0]  issue_rd;
    logic [31:0] issue_addr;
    logic        issue_branch;
    logic [31:0] issue_pred_next;
    logic        issue_full;

    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_val;

    logic        cdb_active;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic [31:0] cdb_addr;

    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_tag;

    logic        flush;
    logic [31:0] redirect_addr;

    modport master (
        output issue_valid, issue_tag, issue_rd, issue_addr, issue_branch, issue_pred_next,
        output wb_valid, wb_tag, wb_val,
        input  issue_full,
        input  cdb_active, cdb_tag, cdb_val, cdb_addr,
        input  commit_valid, commit_rd, commit_val, commit_tag,
        input  flush, redirect_addr
    );

    modport slave (
        input  issue_valid, issue_tag, issue_rd, issue_addr, issue_branch, issue_pred_next,
        input  wb_valid, wb_tag, wb_val,
        output issue_full,
        output cdb_active, cdb_tag, cdb_val, cdb_addr,
        output commit_valid, commit_rd, commit_val, commit_tag,
        output flush, redirect_addr
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records issued instructions, takes results, broadcasts on the CDB,
// retires in order and flushes on a mispredicted branch. Define REORDER_BUFFER_BYPASS_EN to let a
// writeback that matches the head entry retire at the same edge.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave bus
);

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic        branch;
        logic [31:0] pred_next;
        logic [31:0] val;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              cdb_active_q, cdb_active_d;
    logic [3:0]        cdb_tag_q, cdb_tag_d;
    logic [31:0]       cdb_val_q, cdb_val_d;
    logic [31:0]       cdb_addr_q, cdb_addr_d;
    logic              commit_valid_q, commit_valid_d;
    logic [4:0]        commit_rd_q, commit_rd_d;
    logic [31:0]       commit_val_q, commit_val_d;
    logic [3:0]        commit_tag_q, commit_tag_d;
    logic              flush_q, flush_d;
    logic [31:0]       redirect_q, redirect_d;

    logic              full;
    logic              wb_fire;
    logic              wb_hit;
    logic [PTR_W-1:0]  wb_idx;
    logic              bypass;
    entry_t            head_ent;
    logic              commit_fire;
    logic [31:0]       commit_value;
    logic              mispredict;
    logic              issue_fire;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign wb_fire  = rdy_in && bus.wb_valid && (bus.wb_tag != 4'd0);
    assign head_ent = ent_q[head_q];

    // Tags recycle, so only the oldest still-unready holder of the tag may take the result.
    always_comb begin
        wb_hit = 1'b0;
        wb_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!wb_hit
                && ent_q[head_q + PTR_W'(i)].busy
                && !ent_q[head_q + PTR_W'(i)].ready
                && (ent_q[head_q + PTR_W'(i)].tag == bus.wb_tag)) begin
                wb_hit = 1'b1;
                wb_idx = head_q + PTR_W'(i);
            end
        end
    end

`ifdef REORDER_BUFFER_BYPASS_EN
    assign bypass = wb_fire && wb_hit && (wb_idx == head_q);
`else
    assign bypass = 1'b0;
`endif

    assign commit_fire  = rdy_in && head_ent.busy && (head_ent.ready || bypass);
    assign commit_value = head_ent.ready ? head_ent.val : bus.wb_val;
    assign mispredict   = commit_fire && head_ent.branch && (commit_value != head_ent.pred_next);
    assign issue_fire   = rdy_in && bus.issue_valid && !full && !mispredict;

    // While paused everything holds, including pulse flops, so no event is lost across a pause.
    always_comb begin
        ent_d          = ent_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        cdb_active_d   = cdb_active_q;
        cdb_tag_d      = cdb_tag_q;
        cdb_val_d      = cdb_val_q;
        cdb_addr_d     = cdb_addr_q;
        commit_valid_d = commit_valid_q;
        commit_rd_d    = commit_rd_q;
        commit_val_d   = commit_val_q;
        commit_tag_d   = commit_tag_q;
        flush_d        = flush_q;
        redirect_d     = redirect_q;

        if (rdy_in) begin
            cdb_active_d   = wb_fire;
            commit_valid_d = commit_fire;
            flush_d        = mispredict;

            if (wb_fire) begin
                cdb_tag_d  = bus.wb_tag;
                cdb_val_d  = bus.wb_val;
                cdb_addr_d = wb_hit ? ent_q[wb_idx].addr : 32'd0;
                if (wb_hit) begin
                    ent_d[wb_idx].ready = 1'b1;
                    ent_d[wb_idx].val   = bus.wb_val;
                end
            end

            if (commit_fire) begin
                commit_rd_d          = head_ent.rd;
                commit_val_d         = commit_value;
                commit_tag_d         = head_ent.tag;
                ent_d[head_q].busy   = 1'b0;
                ent_d[head_q].ready  = 1'b0;
                head_d               = head_q + PTR_W'(1);
            end

            if (issue_fire) begin
                ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, tag: bus.issue_tag, rd: bus.issue_rd,
                                  addr: bus.issue_addr, branch: bus.issue_branch,
                                  pred_next: bus.issue_pred_next, val: 32'd0};
                tail_d        = tail_q + PTR_W'(1);
            end

            if (issue_fire && !commit_fire) begin
                count_d = count_q + (PTR_W+1)'(1);
            end else if (!issue_fire && commit_fire) begin
                count_d = count_q - (PTR_W+1)'(1);
            end

            // A mispredict squashes every younger entry, including any same-edge writeback.
            if (mispredict) begin
                redirect_d = commit_value;
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i].busy  = 1'b0;
                    ent_d[i].ready = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            cdb_active_q   <= 1'b0;
            cdb_tag_q      <= '0;
            cdb_val_q      <= '0;
            cdb_addr_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_tag_q   <= '0;
            flush_q        <= 1'b0;
            redirect_q     <= '0;
        end else begin
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            cdb_active_q   <= cdb_active_d;
            cdb_tag_q      <= cdb_tag_d;
            cdb_val_q      <= cdb_val_d;
            cdb_addr_q     <= cdb_addr_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_tag_q   <= commit_tag_d;
            flush_q        <= flush_d;
            redirect_q     <= redirect_d;
        end
    end

    assign bus.issue_full    = full;
    assign bus.cdb_active    = cdb_active_q & rdy_in;
    assign bus.cdb_tag       = cdb_tag_q;
    assign bus.cdb_val       = cdb_val_q;
    assign bus.cdb_addr      = cdb_addr_q;
    assign bus.commit_valid  = commit_valid_q & rdy_in;
    assign bus.commit_rd     = commit_rd_q;
    assign bus.commit_val    = commit_val_q;
    assign bus.commit_tag    = commit_tag_q;
    assign bus.flush         = flush_q & rdy_in;
    assign bus.redirect_addr = redirect_q;

endmodule
